// File: rtl/muldiv_unit.sv
// Multi-cycle HI/LO multiply/divide unit for the EX stage, with pipeline stall request.
// Define MDU_MADD_EN to add MADD/MSUB (op 110/111) accumulate into {HI,LO}.
module muldiv_unit #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             md_use_d,
    output logic             busy,
    output logic             stall_req,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    localparam logic [2:0] OpMult  = 3'b000;
    localparam logic [2:0] OpMultu = 3'b001;
    localparam logic [2:0] OpDiv   = 3'b010;
    localparam logic [2:0] OpDivu  = 3'b011;
    localparam logic [2:0] OpMthi  = 3'b100;
    localparam logic [2:0] OpMtlo  = 3'b101;
`ifdef MDU_MADD_EN
    localparam logic [2:0] OpMadd  = 3'b110;
    localparam logic [2:0] OpMsub  = 3'b111;
`endif

    typedef enum logic {
        StIdle,
        StBusy
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [2:0]        op_q, op_d;
    logic [WIDTH-1:0]  hi_q, hi_d;
    logic [WIDTH-1:0]  lo_q, lo_d;

    logic                 is_mul_op;
    logic                 is_div_op;
    logic                 mul_signed;
    logic [2*WIDTH-1:0]   prod;
    logic                 div_signed;
    logic                 a_neg;
    logic                 b_neg;
    logic [WIDTH-1:0]     abs_a;
    logic [WIDTH-1:0]     abs_b;
    logic [WIDTH-1:0]     divisor;
    logic [WIDTH-1:0]     q_mag;
    logic [WIDTH-1:0]     r_mag;
    logic [WIDTH-1:0]     div_hi;
    logic [WIDTH-1:0]     div_lo;
    logic [2*WIDTH-1:0]   result;

    // Decode of the incoming EX-stage op
    always_comb begin
        is_mul_op = (op == OpMult) || (op == OpMultu);
`ifdef MDU_MADD_EN
        is_mul_op = is_mul_op || (op == OpMadd) || (op == OpMsub);
`endif
        is_div_op = (op == OpDiv) || (op == OpDivu);
    end

    // One 2W-bit multiplier; sign extension selects signed vs unsigned, low 2W bits are exact
    always_comb begin
        mul_signed = (op_q != OpMultu);
        prod = {{WIDTH{mul_signed & a_q[WIDTH-1]}}, a_q} *
               {{WIDTH{mul_signed & b_q[WIDTH-1]}}, b_q};
    end

    // Signed divide via magnitudes; the most-negative / -1 case naturally yields LO=A, HI=0
    always_comb begin
        div_signed = (op_q == OpDiv);
        a_neg      = div_signed & a_q[WIDTH-1];
        b_neg      = div_signed & b_q[WIDTH-1];
        abs_a      = a_neg ? -a_q : a_q;
        abs_b      = b_neg ? -b_q : b_q;
        divisor    = (b_q == '0) ? WIDTH'(1) : abs_b;
        q_mag      = abs_a / divisor;
        r_mag      = abs_a % divisor;
        if (b_q == '0) begin
            div_lo = '1;
            div_hi = a_q;
        end else begin
            div_lo = (a_neg ^ b_neg) ? -q_mag : q_mag;
            div_hi = a_neg ? -r_mag : r_mag;
        end
    end

    always_comb begin
        case (op_q)
            OpDiv, OpDivu: result = {div_hi, div_lo};
`ifdef MDU_MADD_EN
            OpMadd:        result = {hi_q, lo_q} + prod;
            OpMsub:        result = {hi_q, lo_q} - prod;
`endif
            default:       result = prod;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    if (is_mul_op || is_div_op) begin
                        a_d     = A;
                        b_d     = B;
                        op_d    = op;
                        cnt_d   = is_div_op ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);
                        busy_d  = 1'b1;
                        state_d = StBusy;
                    end else if (op == OpMthi) begin
                        hi_d = A;
                    end else if (op == OpMtlo) begin
                        lo_d = A;
                    end
                end
            end
            StBusy: begin
                // start while busy is deliberately ignored
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    {hi_d, lo_d} = result;
                    busy_d       = 1'b0;
                    state_d      = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy      = busy_q;
    assign stall_req = busy_q & (md_use_d | start);
    assign HI        = hi_q;
    assign LO        = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus random ops against an arithmetic model.
module tb_muldiv_unit;

    localparam int unsigned W  = 32;
    localparam int unsigned MC = 5;
    localparam int unsigned DC = 10;
`ifdef MDU_MADD_EN
    localparam bit MaddEn = 1'b1;
`else
    localparam bit MaddEn = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [2:0]    op;
    logic [W-1:0]  A;
    logic [W-1:0]  B;
    logic          md_use_d;
    logic          busy;
    logic          stall_req;
    logic [W-1:0]  HI;
    logic [W-1:0]  LO;

    int n_total = 0;
    int n_bad   = 0;
    logic [W-1:0] hi_m;
    logic [W-1:0] lo_m;

    muldiv_unit #(
        .WIDTH       (W),
        .MULT_CYCLES (MC),
        .DIV_CYCLES  (DC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .A         (A),
        .B         (B),
        .md_use_d  (md_use_d),
        .busy      (busy),
        .stall_req (stall_req),
        .HI        (HI),
        .LO        (LO)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic int exp_latency(input logic [2:0] o);
        case (o)
            3'd0, 3'd1: return MC;
            3'd2, 3'd3: return DC;
            3'd6, 3'd7: return MaddEn ? MC : 0;
            default:    return 0;
        endcase
    endfunction

    // Expected {HI,LO} after op o, from plain 64-bit arithmetic
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] hi,
                                          input logic [31:0] lo);
        longint sp;
        int qa;
        int qb;
        logic [63:0] acc;
        acc = {hi, lo};
        sp  = longint'($signed(a)) * longint'($signed(b));
        case (o)
            3'd0: return sp;
            3'd1: return {32'h0, a} * {32'h0, b};
            3'd2: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, a};
                qa = $signed(a);
                qb = $signed(b);
                return {32'(qa % qb), 32'(qa / qb)};
            end
            3'd3: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            3'd4: return {a, lo};
            3'd5: return {hi, a};
            3'd6: return MaddEn ? acc + 64'(sp) : acc;
            default: return MaddEn ? acc - 64'(sp) : acc;
        endcase
    endfunction

    // Issue one op at a negedge, count busy cycles, optionally pulse a second start mid-flight
    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic use_d, input int inject_at);
        logic [63:0] exp;
        int cycles;
        exp = model(o, a, b, hi_m, lo_m);
        op = o;
        A = a;
        B = b;
        md_use_d = use_d;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cycles = 0;
        while (busy === 1'b1 && cycles < 200) begin
            if (cycles == inject_at) begin
                start = 1'b1;
                op = 3'b010;
                A = $urandom;
                B = $urandom;
            end
            #1;
            check_eq($sformatf("stall op%0d c%0d", o, cycles), 64'(stall_req),
                     64'(md_use_d | start));
            cycles++;
            @(negedge clk);
            start = 1'b0;
        end
        check_eq($sformatf("latency op%0d", o), 64'(cycles), 64'(exp_latency(o)));
        check_eq($sformatf("hilo op%0d a=%h b=%h", o, a, b), {HI, LO}, exp);
        {hi_m, lo_m} = exp;
    endtask

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        int          sel;
        reset = 1'b1;
        start = 1'b0;
        op = '0;
        A = '0;
        B = '0;
        md_use_d = 1'b1;
        hi_m = '0;
        lo_m = '0;
        repeat (2) @(negedge clk);
        check_eq("reset hilo", {HI, LO}, 64'h0);
        check_eq("reset busy", 64'(busy), 64'h0);
        check_eq("reset stall", 64'(stall_req), 64'h0);
        reset = 1'b0;
        md_use_d = 1'b0;
        @(negedge clk);

        do_op(3'd0, 32'hFFFF_FFFE, 32'd3, 1'b0, -1);
        check_eq("mult const", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFA);
        do_op(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0, -1);
        check_eq("multu const", {HI, LO}, 64'h0000_0002_FFFF_FFFA);
        do_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, -1);
        check_eq("div const", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFD);
        do_op(3'd3, 32'd7, 32'd2, 1'b0, -1);
        check_eq("divu const", {HI, LO}, 64'h0000_0001_0000_0003);
        do_op(3'd3, 32'h1234_5678, 32'd0, 1'b0, -1);
        check_eq("divz const", {HI, LO}, 64'h1234_5678_FFFF_FFFF);
        do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, -1);
        check_eq("divovf const", {HI, LO}, 64'h0000_0000_8000_0000);
        do_op(3'd4, 32'hDEAD_BEEF, 32'd0, 1'b0, -1);
        do_op(3'd5, 32'h0BAD_F00D, 32'd0, 1'b0, -1);
        check_eq("mthi/mtlo const", {HI, LO}, 64'hDEAD_BEEF_0BAD_F00D);
        do_op(3'd0, 32'h0001_0003, 32'hFFFF_0007, 1'b1, 2);

`ifdef MDU_MADD_EN
        do_op(3'd4, 32'd0, 32'd0, 1'b0, -1);
        do_op(3'd5, 32'd10, 32'd0, 1'b0, -1);
        do_op(3'd6, 32'd3, 32'd4, 1'b0, -1);
        check_eq("madd const", {HI, LO}, 64'd22);
        do_op(3'd7, 32'd2, 32'd20, 1'b0, -1);
        check_eq("msub const", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFEE);
`else
        do_op(3'd6, 32'h1111_1111, 32'h2222_2222, 1'b0, -1);
        do_op(3'd7, 32'h3333_3333, 32'h4444_4444, 1'b1, -1);
`endif

        for (int i = 0; i < 60; i++) begin
            ro  = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) rb = '0;
            else if (sel == 1) begin
                ra = 32'h8000_0000;
                rb = 32'hFFFF_FFFF;
            end else if (sel == 2) begin
                ra = 32'($urandom_range(0, 40)) - 32'd20;
                rb = 32'($urandom_range(0, 10)) - 32'd5;
            end
            do_op(ro, ra, rb, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1);
        end

        // Reset in the middle of a divide discards it
        do_op(3'd4, 32'hCAFE_0001, 32'd0, 1'b0, -1);
        op = 3'd2;
        A = 32'd100;
        B = 32'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("busy before reset", 64'(busy), 64'h1);
        #2;
        reset = 1'b1;
        #1;
        check_eq("async reset busy", 64'(busy), 64'h0);
        check_eq("async reset hilo", {HI, LO}, 64'h0);
        @(negedge clk);
        reset = 1'b0;
        repeat (DC + 2) @(negedge clk);
        check_eq("post reset busy", 64'(busy), 64'h0);
        check_eq("post reset hilo", {HI, LO}, 64'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Multi-cycle multiply/divide unit (HI/LO register pair) in the EX stage of the 5-stage MIPS pipeline.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX, holds results in HI/LO for MFHI/MFLO.
- Produces the stall request that freezes the IF/ID and ID/EX pipeline registers while a D-stage instruction needs the unit and it is still computing.

Parameters:
- WIDTH, 32, operand and HI/LO width
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (>=1)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (>=1)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state
- start  input  1  EX-stage instruction is a muldiv op, qualified valid
- op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 see Optional Feature
- A  input  WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO source)
- B  input  WIDTH  rt operand (divisor / multiplier)
- md_use_d  input  1  D-stage instruction is any muldiv op or MFHI/MFLO
- busy  output  1  computation in progress
- stall_req  output  1  combinational: busy & (md_use_d | start)
- HI  output  WIDTH  HI register
- LO  output  WIDTH  LO register

Behaviour:
- Reset:
  - Asynchronous, any time including mid-operation.
  - HI=0, LO=0, busy=0, state IDLE, counter=0, latched operands=0.
  - Operation in flight is discarded.
- States: IDLE, BUSY.
- IDLE, start=1, op MULT/MULTU/DIV/DIVU:
  - Latch A, B, op at edge t.
  - counter <= MULT_CYCLES or DIV_CYCLES.
  - Go to BUSY; busy=1 from cycle t+1.
- BUSY: counter decrements each edge. On the edge where counter==1:
  - HI/LO <= result.
  - busy <= 0.
  - Return to IDLE.
  - Net: busy high exactly N cycles; new HI/LO visible the cycle busy falls.
- MTHI/MTLO in IDLE: single-cycle write of A to HI/LO at the edge; no busy.
- start=1 while BUSY: ignored, no effect. The hazard unit guarantees this never reaches EX because stall_req is high.
- start=1 with op 110/111 and feature disabled: ignored, no state change.
- HI/LO hold their value at all times except on result or MTHI/MTLO write.
- Arithmetic:
  - MULT: {HI,LO} = signed A*B (2*WIDTH bits).
  - MULTU: {HI,LO} = unsigned A*B.
  - DIV: LO = signed quotient, truncating toward zero; HI = remainder with the sign of the dividend.
  - DIVU: unsigned quotient/remainder.
  - Divide by zero (both forms): LO = all ones, HI = A.
  - Signed overflow (A = most-negative, B = -1): LO = A, HI = 0.
- Result computation may be done combinationally from the latched operands at the final edge, or iteratively. Only latency and values are specified.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined:
  - op 110 = MADD: {HI,LO} <= {HI,LO} + signed A*B.
  - op 111 = MSUB: {HI,LO} <= {HI,LO} - signed A*B.
  - Both use MULT_CYCLES latency.
  - The accumulator base is HI/LO sampled at the final edge.
- Not defined: ops 110/111 ignored as above; no accumulate hardware synthesized.

Test Plan:
1. MULT A=0xFFFFFFFE, B=3 -> busy high exactly 5 cycles; after falling, HI=0xFFFFFFFF, LO=0xFFFFFFFA. Same operands with MULTU -> HI=0x00000002, LO=0xFFFFFFFA.
2. DIV A=0xFFFFFFF9 (-7), B=2 -> after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU A=7, B=2 -> LO=3, HI=1.
3. DIVU A=0x12345678, B=0 -> LO=0xFFFFFFFF, HI=0x12345678. DIV A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
4. MTHI A=0xDEADBEEF, then MTLO A=0x0BADF00D on the next cycle -> HI/LO updated on each respective edge; busy never asserted.
5. Start MULT, then hold md_use_d=1 and pulse start=1 with DIV mid-operation -> stall_req=1 for all busy cycles; second start ignored; HI/LO reflect only the MULT.
6. Start DIV, assert reset on cycle 4 between edges -> busy, HI, LO drop to 0 immediately; no later writeback. With MDU_MADD_EN: HI/LO=0/10, MADD A=3, B=4 -> LO=22; MSUB A=2, B=20 -> HI=0xFFFFFFFF, LO=0xFFFFFFEE.
